guess_round_ctrl: RTL and testbench
===================================

Name: guess_round_ctrl

Overview:
Game-round controller sitting directly downstream of the button debouncer. It consumes the debouncer's toggling output and decodes it into single press events. It latches a pseudo-random target number and, on each press, compares the player's switch setting against that target. It scores the answer, presents the result for a fixed time, and sequences a fixed number of rounds before declaring game over.

Parameters:
WIDTH, 8, bit width of target and switch value (1..16)
SCORE_W, 4, width of score and round counters
ROUNDS, 10, rounds per game (1..2^SCORE_W-1)
RESULT_CYC, 50000000, cycles result is held visible (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
btn_toggle  in  1  debounced button state from the debouncer; flips once per stable press and once per stable release
switches  in  WIDTH  player's answer
target  out  WIDTH  number the player must match
result_valid  out  1  high while a round result is displayed
result_correct  out  1  1 = last answer matched; meaningful only when result_valid=1
score  out  SCORE_W  correct answers this game
round_cnt  out  SCORE_W  rounds completed this game
game_over  out  1  high in DONE state

Behaviour:
- Reset is asynchronous, active-low, one clock; all flops clear on rst_n=0. Reset values: target=0, result_valid=0, result_correct=0, score=0, round_cnt=0, game_over=0. Internal reset values: btn_q=0, phase=0, lfsr=16'hACE1, state=NEW_ROUND, hold counter=0.
- Press decode: btn_q registers btn_toggle each cycle. A change exists when btn_toggle!=btn_q.
  - Change with phase=0: press event, phase<=1.
  - Change with phase=1: release, phase<=0, no event.
  - Decode runs in every state, so phase stays aligned even when presses are ignored.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1, right shift; when lsb=1, XOR with 16'hB400. Advances every cycle after reset. It never reaches 0 from the nonzero seed.
- FSM:
  - NEW_ROUND (1 cycle): target<=lfsr[WIDTH-1:0] (pre-advance value); result_valid<=0; go to WAIT_PRESS.
  - WAIT_PRESS: on press event, capture switches of that same cycle into ans_q; go to CHECK.
  - CHECK (1 cycle): result_correct<=(ans_q==target); score<=score+1 when correct, saturating at 2^SCORE_W-1; round_cnt<=round_cnt+1; result_valid<=1; load hold counter with RESULT_CYC-1; go to RESULT.
  - RESULT: press events are ignored (decoded, discarded); decrement the hold counter. At 0: if round_cnt==ROUNDS go to DONE with result_valid<=0 and game_over<=1; otherwise go to NEW_ROUND.
  - DONE: score and round_cnt are held. On a press event: score<=0, round_cnt<=0, game_over<=0; go to NEW_ROUND.
- Latency: for a press event in cycle t, result_valid rises in cycle t+2 and stays high exactly RESULT_CYC cycles. The next target appears in cycle t+2+RESULT_CYC+1.
- First target after reset release is the seed's low bits (8'hE1 for WIDTH=8).
- Switch changes after the press cycle do not affect the checked answer.
- Reset mid-round or mid-RESULT: everything returns to reset values immediately. The first NEW_ROUND after release restarts at the seed.
- If btn_toggle is 1 at reset release, the first cycle decodes as a press. This matches the debouncer's 0 power-up value, so it is not expected in normal operation.

Test Plan:
1. Reset, WIDTH=8 -> target=8'hE1 from the 2nd cycle after release; score=0, round_cnt=0, result_valid=0.
2. switches=8'hE1, flip btn_toggle 0->1 at cycle t, RESULT_CYC=8 -> result_valid=1 over cycles t+2..t+9, result_correct=1, score=1, round_cnt=1; new target = LFSR value at cycle t+10.
3. switches=8'h00 with target 8'hE1, press -> result_correct=0, score unchanged, round_cnt increments. Toggle btn_toggle twice during RESULT -> no extra round.
4. Release toggle (second flip) in WAIT_PRESS -> no check performed; the next flip checks.
5. ROUNDS=2, two correct presses -> after second RESULT, game_over=1, score=2, round_cnt=2. Next press -> score=0, round_cnt=0, game_over=0, new target.
6. Assert rst_n=0 during RESULT -> all outputs at reset values asynchronously. After release, target=8'hE1 again.

Source files
------------

// File: rtl/guess_round_ctrl.sv
// Guessing-game round controller: decodes button presses, draws LFSR targets, scores answers, sequences rounds.
// Latency: a press in cycle t raises result_valid in cycle t+2 for RESULT_CYC cycles; the next target appears in cycle t+RESULT_CYC+3.
// Backpressure: none; presses arriving outside WAIT_PRESS/DONE are decoded to keep the press/release phase aligned, then dropped.
module guess_round_ctrl #(
    parameter int WIDTH      = 8,
    parameter int SCORE_W    = 4,
    parameter int ROUNDS     = 10,
    parameter int RESULT_CYC = 50000000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               btn_toggle,
    input  logic [WIDTH-1:0]   switches,
    output logic [WIDTH-1:0]   target,
    output logic               result_valid,
    output logic               result_correct,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] round_cnt,
    output logic               game_over
);

    // The hold counter only ever holds values up to RESULT_CYC-1
    localparam int                 HOLD_W    = (RESULT_CYC > 1) ? $clog2(RESULT_CYC) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'(RESULT_CYC - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [SCORE_W-1:0] ROUNDS_C  = SCORE_W'(ROUNDS);
    localparam logic [15:0]        LFSR_SEED = 16'hACE1;
    localparam logic [15:0]        LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        S_NEW_ROUND,
        S_WAIT_PRESS,
        S_CHECK,
        S_RESULT,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_btn_q;
    logic                r_phase;
    logic [15:0]         r_lfsr;
    logic [WIDTH-1:0]    r_ans;
    logic [WIDTH-1:0]    r_target;
    logic [HOLD_W-1:0]   r_hold;
    logic                r_result_valid;
    logic                r_result_correct;
    logic [SCORE_W-1:0]  r_score;
    logic [SCORE_W-1:0]  r_round;
    logic                r_game_over;

    logic                w_change;
    logic                w_press;
    logic                w_correct;
    logic                w_load_target;
    logic                w_capture;
    logic                w_check;
    logic                w_hold_dec;
    logic                w_result_end;
    logic                w_end_game;
    logic                w_restart;

    // Every level change of btn_toggle is one edge; odd edges (phase 0) are presses, even ones releases
    assign w_change  = btn_toggle ^ r_btn_q;
    assign w_press   = w_change & ~r_phase;
    assign w_correct = (r_ans == r_target);

    // Press/release phase tracking and free-running Galois LFSR
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btn_q <= 1'b0;
            r_phase <= 1'b0;
            r_lfsr  <= LFSR_SEED;
        end else begin
            r_btn_q <= btn_toggle;
            if (w_change) begin
                r_phase <= ~r_phase;
            end
            r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_NEW_ROUND;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and per-state datapath strobes
    always_comb begin
        w_state_nxt   = r_state;
        w_load_target = 1'b0;
        w_capture     = 1'b0;
        w_check       = 1'b0;
        w_hold_dec    = 1'b0;
        w_result_end  = 1'b0;
        w_end_game    = 1'b0;
        w_restart     = 1'b0;
        case (r_state)
            S_NEW_ROUND: begin
                w_load_target = 1'b1;
                w_state_nxt   = S_WAIT_PRESS;
            end
            S_WAIT_PRESS: begin
                if (w_press) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                w_check     = 1'b1;
                w_state_nxt = S_RESULT;
            end
            S_RESULT: begin
                if (r_hold == '0) begin
                    // Drop result_valid on exit so it is high exactly RESULT_CYC cycles
                    w_result_end = 1'b1;
                    if (r_round == ROUNDS_C) begin
                        w_end_game  = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_NEW_ROUND;
                    end
                end else begin
                    w_hold_dec = 1'b1;
                end
            end
            S_DONE: begin
                if (w_press) begin
                    w_restart   = 1'b1;
                    w_state_nxt = S_NEW_ROUND;
                end
            end
            default: begin
                w_state_nxt = S_NEW_ROUND;
            end
        endcase
    end

    // Target draw, answer capture and result-hold timer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_target <= '0;
            r_ans    <= '0;
            r_hold   <= '0;
        end else begin
            if (w_load_target) begin
                r_target <= r_lfsr[WIDTH-1:0];
            end
            if (w_capture) begin
                r_ans <= switches;
            end
            if (w_check) begin
                r_hold <= HOLD_LOAD;
            end else if (w_hold_dec) begin
                r_hold <= r_hold - 1'b1;
            end
        end
    end

    // Scoring, round counting and result/game-over flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result_valid   <= 1'b0;
            r_result_correct <= 1'b0;
            r_score          <= '0;
            r_round          <= '0;
            r_game_over      <= 1'b0;
        end else begin
            if (w_check) begin
                r_result_valid   <= 1'b1;
                r_result_correct <= w_correct;
                r_round          <= r_round + 1'b1;
                if (w_correct && (r_score != SCORE_MAX)) begin
                    r_score <= r_score + 1'b1;
                end
            end else if (w_result_end || w_load_target) begin
                r_result_valid <= 1'b0;
            end
            if (w_end_game) begin
                r_game_over <= 1'b1;
            end else if (w_restart) begin
                r_game_over <= 1'b0;
                r_score     <= '0;
                r_round     <= '0;
            end
        end
    end

    assign target         = r_target;
    assign result_valid   = r_result_valid;
    assign result_correct = r_result_correct;
    assign score          = r_score;
    assign round_cnt      = r_round;
    assign game_over      = r_game_over;

endmodule

// File: tb/tb_guess_round_ctrl.sv
// Directed bench for guess_round_ctrl with a short result hold and a two-round game.
// Latency: checks result_valid timing cycle by cycle against a press in cycle t.
// Backpressure: n/a; the bench drives btn_toggle/switches freely and samples 1 time unit after each rising edge.
module tb_guess_round_ctrl;

    localparam int WIDTH      = 8;
    localparam int SCORE_W    = 4;
    localparam int ROUNDS     = 2;
    localparam int RESULT_CYC = 8;

    logic               clk;
    logic               rst_n;
    logic               btn_toggle;
    logic [WIDTH-1:0]   switches;
    logic [WIDTH-1:0]   target;
    logic               result_valid;
    logic               result_correct;
    logic [SCORE_W-1:0] score;
    logic [SCORE_W-1:0] round_cnt;
    logic               game_over;

    int n_chk;
    int n_pass;

    // Reference LFSR: x^16+x^14+x^13+x^11+1 Galois, seed ACE1, one step per clock
    logic [15:0] m_lfsr;

    logic [WIDTH-1:0] tgt;
    logic [WIDTH-1:0] nxt_tgt;

    guess_round_ctrl #(
        .WIDTH      (WIDTH),
        .SCORE_W    (SCORE_W),
        .ROUNDS     (ROUNDS),
        .RESULT_CYC (RESULT_CYC)
    ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .btn_toggle     (btn_toggle),
        .switches       (switches),
        .target         (target),
        .result_valid   (result_valid),
        .result_correct (result_correct),
        .score          (score),
        .round_cnt      (round_cnt),
        .game_over      (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 16'hACE1;
        else        m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic flip();
        btn_toggle = ~btn_toggle;
    endtask

    // Press with answer sw in cycle t, follow the result window, return target drawn afterwards
    task automatic run_round(input logic [WIDTH-1:0] sw, input logic exp_corr,
                             input logic [SCORE_W-1:0] exp_score, input logic [SCORE_W-1:0] exp_rnd,
                             input int n_tog, input logic exp_done, output logic [WIDTH-1:0] next_tgt);
        logic [WIDTH-1:0] lf;
        lf = '0;
        next_tgt = '0;
        switches = sw;
        flip();
        step();                                   // cycle t+1
        switches = ~sw;                           // late change must not matter
        chk("rv_t1", result_valid, 1'b0);
        for (int k = 2; k <= 9; k++) begin
            step();
            chk("rv_window", result_valid, 1'b1);
            if (k == 2) begin
                chk("correct", result_correct, exp_corr);
                chk("score", score, exp_score);
                chk("round", round_cnt, exp_rnd);
            end
            if ((k == 3 || k == 5) && n_tog > (k - 3) / 2) flip();
        end
        step();                                   // cycle t+10
        chk("rv_end", result_valid, 1'b0);
        chk("game_over", game_over, exp_done);
        chk("score_hold", score, exp_score);
        chk("round_hold", round_cnt, exp_rnd);
        lf = m_lfsr[WIDTH-1:0];
        step();                                   // cycle t+11
        if (!exp_done) begin
            chk("next_target", target, lf);
            next_tgt = lf;
        end
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        rst_n = 1'b0;
        btn_toggle = 1'b0;
        switches = '0;
        tgt = '0;
        nxt_tgt = '0;
        step();
        step();
        chk("rst_target", target, 8'h00);
        chk("rst_rv", result_valid, 1'b0);
        chk("rst_score", score, 4'd0);
        chk("rst_round", round_cnt, 4'd0);
        chk("rst_go", game_over, 1'b0);

        rst_n = 1'b1;
        step();
        step();
        chk("first_target", target, 8'hE1);
        tgt = 8'hE1;

        // Round 1 correct
        run_round(tgt, 1'b1, 4'd1, 4'd1, 0, 1'b0, nxt_tgt);
        tgt = nxt_tgt;

        // Release edge in WAIT_PRESS performs no check
        flip();
        for (int i = 0; i < 4; i++) step();
        chk("release_no_rv", result_valid, 1'b0);
        chk("release_no_round", round_cnt, 4'd1);

        // Round 2 correct, with release + ignored press during RESULT, ends game
        run_round(tgt, 1'b1, 4'd2, 4'd2, 2, 1'b1, nxt_tgt);

        // Phase is 1: first flip in DONE is a release, game stays over
        flip();
        for (int i = 0; i < 3; i++) step();
        chk("done_hold_go", game_over, 1'b1);
        chk("done_hold_score", score, 4'd2);
        chk("done_hold_round", round_cnt, 4'd2);

        // Press in DONE restarts the game
        flip();
        step();
        tgt = m_lfsr[WIDTH-1:0];
        step();
        chk("restart_score", score, 4'd0);
        chk("restart_round", round_cnt, 4'd0);
        chk("restart_go", game_over, 1'b0);
        chk("restart_target", target, tgt);

        // Game 2: wrong answer, then reset mid-RESULT
        flip();
        step();
        step();
        switches = ~tgt;
        flip();
        step();
        step();
        chk("g2_rv", result_valid, 1'b1);
        chk("g2_correct", result_correct, 1'b0);
        chk("g2_score", score, 4'd0);
        chk("g2_round", round_cnt, 4'd1);
        step();
        #2;
        rst_n = 1'b0;
        btn_toggle = 1'b0;
        #1;
        chk("arst_rv", result_valid, 1'b0);
        chk("arst_correct", result_correct, 1'b0);
        chk("arst_target", target, 8'h00);
        chk("arst_round", round_cnt, 4'd0);
        chk("arst_go", game_over, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        step();
        step();
        chk("rerst_target", target, 8'hE1);

        // Game 3: switches 00 against E1 is wrong, round still counts
        run_round(8'h00, 1'b0, 4'd0, 4'd1, 0, 1'b0, nxt_tgt);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
